// File: rtl/xentry_pkg.sv
// Shared memory-request types plus the write-buffer FSM states and entry layout.
package xentry_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      STORE   = 2'd1,
      CLFLUSH = 2'd2
   } memory_operation_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DRAIN     = 2'd1,
      LOAD_MISS = 2'd2
   } wbuf_state_e;

   localparam int WBUF_XLEN = 32;

   // Canonical entry layout for the default 32-bit build.
   typedef struct packed {
      logic                 valid;
      logic [WBUF_XLEN-1:2] addr;
      logic [WBUF_XLEN-1:0] data;
   } wbuf_entry_t;

endpackage

// File: rtl/l2_wbuf_entry_array.sv
// Write-buffer entry storage with associative word match, tail allocate,
// in-place coalesce and head invalidate.
module l2_wbuf_entry_array #(
   parameter int  XLEN  = 32,
   parameter int  DEPTH = 4,
   localparam int IW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:2]  lookup_word,
   output logic [DEPTH-1:0] hit_vec,
   output logic [IW-1:0]    hit_index,
   output logic [XLEN-1:0]  hit_data,
   input  logic [IW-1:0]    head_index,
   output logic [XLEN-1:0]  head_address,
   output logic [XLEN-1:0]  head_data,
   input  logic             alloc_en,
   input  logic [IW-1:0]    alloc_index,
   input  logic             coalesce_en,
   input  logic [XLEN-1:0]  write_data,
   input  logic             invalidate_en
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:2] addr;
      logic [XLEN-1:0] data;
   } entry_t;

   entry_t entries [DEPTH];

   // Coalescing guarantees at most one valid entry per word, so the hit vector is one-hot.
   always_comb begin
      hit_vec   = '0;
      hit_index = '0;
      hit_data  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entries[i].valid && (entries[i].addr == lookup_word)) begin
            hit_vec[i] = 1'b1;
            hit_index  = IW'(i);
            hit_data   = entries[i].data;
         end
      end
   end

   assign head_address = {entries[head_index].addr, 2'b00};
   assign head_data    = entries[head_index].data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc_en && (alloc_index == IW'(i))) begin
               entries[i].valid <= 1'b1;
               entries[i].addr  <= lookup_word;
               entries[i].data  <= write_data;
            end else if (coalesce_en && (hit_index == IW'(i))) begin
               entries[i].data <= write_data;
            end else if (invalidate_en && (head_index == IW'(i))) begin
               entries[i].valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/l2_write_buffer.sv
// L2-side write buffer: absorbs dcache stores, coalesces, forwards loads, drains to memory.
// Define WBUF_PERF_COUNTERS_EN to build the coalesce/forward performance counters.
module l2_write_buffer
   import xentry_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   l2_req_address,
   input  memory_operation_e l2_req_type,
   input  logic              l2_req_valid,
   input  logic [XLEN-1:0]   l2_word_to_store,
   output logic [XLEN-1:0]   l2_fetched_word,
   output logic              l2_req_fulfilled,
   output logic [XLEN-1:0]   mem_req_address,
   output memory_operation_e mem_req_type,
   output logic              mem_req_valid,
   output logic [XLEN-1:0]   mem_word_to_store,
   input  logic [XLEN-1:0]   mem_fetched_word,
   input  logic              mem_req_fulfilled,
   output logic              wbuf_empty,
   output logic [31:0]       perf_coalesce_count,
   output logic [31:0]       perf_forward_count
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   wbuf_state_e      state, state_next;
   logic [IW-1:0]    head, tail;
   logic [CW-1:0]    count, count_next;
   logic [DEPTH-1:0] hit_vec;
   logic [IW-1:0]    hit_index;
   logic [XLEN-1:0]  hit_data, head_address, head_data;
   logic             hit, head_busy, full, active;
   logic             is_store, is_load, is_flush;
   logic             coalesce, enqueue, pop, load_fwd, load_miss;

   l2_wbuf_entry_array #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) entry_array (
      .clk           (clk),
      .reset         (reset),
      .lookup_word   (l2_req_address[XLEN-1:2]),
      .hit_vec       (hit_vec),
      .hit_index     (hit_index),
      .hit_data      (hit_data),
      .head_index    (head),
      .head_address  (head_address),
      .head_data     (head_data),
      .alloc_en      (enqueue),
      .alloc_index   (tail),
      .coalesce_en   (coalesce),
      .write_data    (l2_word_to_store),
      .invalidate_en (pop)
   );

   assign active   = l2_req_valid && !reset;
   assign is_store = active && (l2_req_type == STORE);
   assign is_load  = active && (l2_req_type == LOAD);
   assign is_flush = active && (l2_req_type == CLFLUSH);

   // The head entry is frozen while it is on the memory bus, so a store to it waits for the pop.
   assign hit       = |hit_vec;
   assign head_busy = (state == DRAIN) && hit && (hit_index == head);
   assign full      = (count == CW'(DEPTH));
   assign coalesce  = is_store && hit && !head_busy;
   assign enqueue   = is_store && !hit && !full;
   assign pop       = (state == DRAIN) && mem_req_fulfilled;
   assign load_fwd  = is_load && hit;
   assign load_miss = is_load && !hit;

   assign count_next = count + CW'(enqueue) - CW'(pop);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (load_miss) begin
               state_next = LOAD_MISS;
            end else if (count != '0) begin
               state_next = DRAIN;
            end
         end
         DRAIN:     if (mem_req_fulfilled) state_next = IDLE;
         LOAD_MISS: if (mem_req_fulfilled) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         wbuf_empty <= 1'b1;
      end else begin
         state      <= state_next;
         head       <= head + IW'(pop);
         tail       <= tail + IW'(enqueue);
         count      <= count_next;
         wbuf_empty <= (count_next == '0);
      end
   end

   assign mem_req_valid     = (state == DRAIN) || (state == LOAD_MISS);
   assign mem_req_type      = (state == LOAD_MISS) ? LOAD : STORE;
   assign mem_req_address   = (state == LOAD_MISS) ? l2_req_address : head_address;
   assign mem_word_to_store = head_data;

   // Load misses are answered straight from the memory port while the FSM owns the request.
   always_comb begin
      l2_req_fulfilled = 1'b0;
      l2_fetched_word  = '0;
      if (is_store) begin
         l2_req_fulfilled = coalesce || enqueue;
      end else if (load_fwd) begin
         l2_req_fulfilled = 1'b1;
         l2_fetched_word  = hit_data;
      end else if (load_miss && (state == LOAD_MISS)) begin
         l2_req_fulfilled = mem_req_fulfilled;
         l2_fetched_word  = mem_fetched_word;
      end else if (is_flush) begin
         l2_req_fulfilled = (count == '0) && (state == IDLE);
      end
   end

`ifdef WBUF_PERF_COUNTERS_EN
   logic [31:0] coalesce_count, forward_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         coalesce_count <= '0;
         forward_count  <= '0;
      end else begin
         coalesce_count <= coalesce_count + 32'(coalesce);
         forward_count  <= forward_count + 32'(load_fwd);
      end
   end

   assign perf_coalesce_count = coalesce_count;
   assign perf_forward_count  = forward_count;
`else
   assign perf_coalesce_count = '0;
   assign perf_forward_count  = '0;
`endif

endmodule

// File: tb/tb_l2_write_buffer.sv
// Scoreboard bench for l2_write_buffer: directed dcache requests, queued expectations
// checked by independent l2-side and memory-side monitors.
`timescale 1ns/1ps
module tb_l2_write_buffer;
   import xentry_pkg::*;

   logic              clk;
   logic              reset;
   logic [31:0]       l2_req_address;
   memory_operation_e l2_req_type;
   logic              l2_req_valid;
   logic [31:0]       l2_word_to_store;
   logic [31:0]       l2_fetched_word;
   logic              l2_req_fulfilled;
   logic [31:0]       mem_req_address;
   memory_operation_e mem_req_type;
   logic              mem_req_valid;
   logic [31:0]       mem_word_to_store;
   logic [31:0]       mem_fetched_word;
   logic              mem_req_fulfilled;
   logic              wbuf_empty;
   logic [31:0]       perf_coalesce_count;
   logic [31:0]       perf_forward_count;

   typedef struct {
      memory_operation_e op;
      logic [31:0]       addr;
      logic [31:0]       data;
   } txn_t;

   txn_t        exp_l2[$];
   txn_t        exp_mem[$];
   txn_t        l2_t, mem_t;
   int          assertion_count = 0;
   int          fail_count = 0;
   logic        mem_stall = 1'b1;
   int          mem_latency = 0;
   logic [31:0] mem_load_data = '0;
   int          wait_cnt = 0;

   l2_write_buffer #(.XLEN(32), .DEPTH(4)) dut (
      .clk                 (clk),
      .reset               (reset),
      .l2_req_address      (l2_req_address),
      .l2_req_type         (l2_req_type),
      .l2_req_valid        (l2_req_valid),
      .l2_word_to_store    (l2_word_to_store),
      .l2_fetched_word     (l2_fetched_word),
      .l2_req_fulfilled    (l2_req_fulfilled),
      .mem_req_address     (mem_req_address),
      .mem_req_type        (mem_req_type),
      .mem_req_valid       (mem_req_valid),
      .mem_word_to_store   (mem_word_to_store),
      .mem_fetched_word    (mem_fetched_word),
      .mem_req_fulfilled   (mem_req_fulfilled),
      .wbuf_empty          (wbuf_empty),
      .perf_coalesce_count (perf_coalesce_count),
      .perf_forward_count  (perf_forward_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertion_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name, input string what);
      assertion_count++;
      fail_count++;
      $display("[TB] FAIL %s: %s", name, what);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expectMem(input memory_operation_e op, input logic [31:0] addr, input logic [31:0] data);
      txn_t t;
      t.op = op;
      t.addr = addr;
      t.data = data;
      exp_mem.push_back(t);
   endtask

   // Called at posedge+1; holds the request until fulfilled (or timeout), then drops valid.
   task automatic applyStimulus(input memory_operation_e op, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] exp_word,
                                input int timeout, output int waited);
      txn_t t;
      bit   done;
      t.op = op;
      t.addr = addr;
      t.data = exp_word;
      exp_l2.push_back(t);
      l2_req_type      = op;
      l2_req_address   = addr;
      l2_word_to_store = data;
      l2_req_valid     = 1'b1;
      waited = 0;
      done   = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (l2_req_fulfilled) begin
            done = 1'b1;
         end else begin
            waited++;
            if (waited >= timeout) begin
               failNow("l2_timeout", $sformatf("request 0x%08h never fulfilled in %0d cycles", addr, timeout));
               void'(exp_l2.pop_back());
               done = 1'b1;
            end
         end
      end
      nextCycle();
      l2_req_valid = 1'b0;
   endtask

   task automatic waitDrained(input string name, input int timeout);
      int n = 0;
      while (!(wbuf_empty && !mem_req_valid) && (n < timeout)) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, {31'b0, wbuf_empty && !mem_req_valid}, 32'd1);
      nextCycle();
   endtask

   // Memory model: fulfils a held request after mem_latency extra cycles unless stalled.
   initial begin
      mem_req_fulfilled = 1'b0;
      mem_fetched_word  = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_req_fulfilled = 1'b0;
         if (mem_req_valid && !mem_stall && !reset) begin
            if (wait_cnt >= mem_latency) begin
               mem_req_fulfilled = 1'b1;
               mem_fetched_word  = mem_load_data;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (l2_req_valid && l2_req_fulfilled) begin
            if (exp_l2.size() == 0) begin
               failNow("l2_unexpected", "fulfilled with nothing expected");
            end else begin
               l2_t = exp_l2.pop_front();
               if (l2_t.op == LOAD) checkOutput("l2_load_data", l2_fetched_word, l2_t.data);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mem_req_valid && mem_req_fulfilled) begin
            if (exp_mem.size() == 0) begin
               failNow("mem_unexpected", $sformatf("transaction to 0x%08h not expected", mem_req_address));
            end else begin
               mem_t = exp_mem.pop_front();
               checkOutput("mem_type", 32'(mem_req_type), 32'(mem_t.op));
               checkOutput("mem_address", mem_req_address, mem_t.addr);
               if (mem_t.op == STORE) checkOutput("mem_data", mem_word_to_store, mem_t.data);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waited;
      reset            = 1'b1;
      l2_req_valid     = 1'b0;
      l2_req_type      = LOAD;
      l2_req_address   = '0;
      l2_word_to_store = '0;

      repeat (2) @(negedge clk);
      checkOutput("reset_wbuf_empty", {31'b0, wbuf_empty}, 32'd1);
      checkOutput("reset_mem_valid", {31'b0, mem_req_valid}, 32'd0);
      checkOutput("reset_l2_fulfilled", {31'b0, l2_req_fulfilled}, 32'd0);
      checkOutput("reset_fetched_word", l2_fetched_word, 32'd0);
      checkOutput("reset_perf_coalesce", perf_coalesce_count, 32'd0);
      checkOutput("reset_perf_forward", perf_forward_count, 32'd0);
      nextCycle();
      reset = 1'b0;

      $display("[TB] store then forwarded load");
      mem_stall = 1'b1;
      expectMem(STORE, 32'h1000, 32'hDEADBEEF);
      applyStimulus(STORE, 32'h1000, 32'hDEADBEEF, 32'h0, 20, waited);
      checkOutput("t1_store_same_cycle", waited, 32'd0);
      @(negedge clk);
      checkOutput("t1_empty_falls", {31'b0, wbuf_empty}, 32'd0);
      nextCycle();
      applyStimulus(LOAD, 32'h1000, 32'h0, 32'hDEADBEEF, 20, waited);
      checkOutput("t1_forward_same_cycle", waited, 32'd0);
      @(negedge clk);
      checkOutput("t1_no_mem_load", 32'(mem_req_type), 32'(STORE));
      nextCycle();

      $display("[TB] coalescing stores");
      expectMem(STORE, 32'h2000, 32'h22);
      applyStimulus(STORE, 32'h2000, 32'h11, 32'h0, 20, waited);
      checkOutput("t2_alloc_same_cycle", waited, 32'd0);
      applyStimulus(STORE, 32'h2002, 32'h22, 32'h0, 20, waited);
      checkOutput("t2_coalesce_same_cycle", waited, 32'd0);
      applyStimulus(LOAD, 32'h2000, 32'h0, 32'h22, 20, waited);
      checkOutput("t2_forward_same_cycle", waited, 32'd0);
`ifdef WBUF_PERF_COUNTERS_EN
      checkOutput("t2_perf_coalesce", perf_coalesce_count, 32'd1);
      checkOutput("t2_perf_forward", perf_forward_count, 32'd2);
`else
      checkOutput("t2_perf_coalesce", perf_coalesce_count, 32'd0);
      checkOutput("t2_perf_forward", perf_forward_count, 32'd0);
`endif
      mem_stall = 1'b0;
      waitDrained("t2_drained", 100);
      checkOutput("t2_all_drained", exp_mem.size(), 32'd0);

      $display("[TB] full buffer stall");
      mem_stall   = 1'b1;
      mem_latency = 0;
      for (int i = 0; i < 4; i++) begin
         expectMem(STORE, 32'(i * 16), 32'(i + 1));
         applyStimulus(STORE, 32'(i * 16), 32'(i + 1), 32'h0, 20, waited);
         checkOutput("t3_enqueue_same_cycle", waited, 32'd0);
      end
      expectMem(STORE, 32'h40, 32'h5);
      fork
         applyStimulus(STORE, 32'h40, 32'h5, 32'h0, 50, waited);
         begin
            repeat (4) @(negedge clk);
            checkOutput("t3_full_not_fulfilled", {31'b0, l2_req_fulfilled}, 32'd0);
            mem_stall = 1'b0;
         end
      join
      checkOutput("t3_full_waited", {31'b0, waited > 4}, 32'd1);
      waitDrained("t3_drained", 100);
      checkOutput("t3_all_drained", exp_mem.size(), 32'd0);

      $display("[TB] load miss behind a drain");
      mem_stall     = 1'b1;
      mem_latency   = 3;
      mem_load_data = 32'hCAFE0001;
      applyStimulus(STORE, 32'h5000, 32'hA5, 32'h0, 20, waited);
      applyStimulus(STORE, 32'h6000, 32'hB6, 32'h0, 20, waited);
      expectMem(STORE, 32'h5000, 32'hA5);
      expectMem(LOAD, 32'h3000, 32'h0);
      expectMem(STORE, 32'h6000, 32'hB6);
      mem_stall = 1'b0;
      applyStimulus(LOAD, 32'h3000, 32'h0, 32'hCAFE0001, 100, waited);
      checkOutput("t4_miss_waits", {31'b0, waited > 0}, 32'd1);
      applyStimulus(LOAD, 32'h6000, 32'h0, 32'hB6, 20, waited);
      checkOutput("t4_entry_intact", waited, 32'd0);
      waitDrained("t4_drained", 100);
      checkOutput("t4_all_drained", exp_mem.size(), 32'd0);

      $display("[TB] clflush barrier");
      mem_stall   = 1'b1;
      mem_latency = 1;
      for (int i = 0; i < 3; i++) begin
         expectMem(STORE, 32'h7000 + 32'(i * 4), 32'hC1 + 32'(i));
         applyStimulus(STORE, 32'h7000 + 32'(i * 4), 32'hC1 + 32'(i), 32'h0, 20, waited);
      end
      fork
         applyStimulus(CLFLUSH, 32'h0, 32'h0, 32'h0, 100, waited);
         begin
            repeat (3) @(negedge clk);
            checkOutput("t5_flush_blocked", {31'b0, l2_req_fulfilled}, 32'd0);
            mem_stall = 1'b0;
         end
      join
      checkOutput("t5_flush_after_drain", exp_mem.size(), 32'd0);
      @(negedge clk);
      checkOutput("t5_empty_after_flush", {31'b0, wbuf_empty}, 32'd1);
      nextCycle();

      $display("[TB] reset during drain");
      mem_stall = 1'b1;
      applyStimulus(STORE, 32'h8000, 32'hE1, 32'h0, 20, waited);
      applyStimulus(STORE, 32'h8004, 32'hE2, 32'h0, 20, waited);
      @(negedge clk);
      checkOutput("t6_draining", {31'b0, mem_req_valid}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t6_async_mem_valid", {31'b0, mem_req_valid}, 32'd0);
      checkOutput("t6_async_empty", {31'b0, wbuf_empty}, 32'd1);
      checkOutput("t6_perf_coalesce", perf_coalesce_count, 32'd0);
      checkOutput("t6_perf_forward", perf_forward_count, 32'd0);
      nextCycle();
      reset     = 1'b0;
      mem_stall = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("t6_entries_discarded", {31'b0, mem_req_valid}, 32'd0);
      checkOutput("t6_still_empty", {31'b0, wbuf_empty}, 32'd1);

      checkOutput("final_l2_queue", exp_l2.size(), 32'd0);
      checkOutput("final_mem_queue", exp_mem.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, fail_count);
      $finish;
   end

endmodule
